// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register reservation scoreboard.
// Tag-matched write-back releases a reservation. Reads bypass accepted write-backs. Flush clears all reservations.
module regfile_scoreboard #(
    parameter int W_OPR    = 32,
    parameter int N_REG    = 32,
    parameter int N_RD     = 2,
    parameter int N_WB     = 2,
    parameter int W_TAG    = 4,
    parameter int ZERO_REG = 1,
    localparam int W_ADDR  = $clog2(N_REG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_RD*W_ADDR-1:0]  rd_addr_i,
    output logic [N_RD*W_OPR-1:0]   rd_data_o,
    output logic [N_RD-1:0]         rd_busy_o,
    input  logic                    res_valid_i,
    input  logic [W_ADDR-1:0]       res_addr_i,
    input  logic [W_TAG-1:0]        res_tag_i,
    input  logic [N_WB-1:0]         wb_valid_i,
    input  logic [N_WB*W_ADDR-1:0]  wb_addr_i,
    input  logic [N_WB*W_TAG-1:0]   wb_tag_i,
    input  logic [N_WB*W_OPR-1:0]   wb_data_i,
    input  logic                    flush_i
);

    logic [W_OPR-1:0]  r_data [N_REG];
    logic [W_TAG-1:0]  r_tag  [N_REG];
    logic [N_REG-1:0]  r_busy;

    logic [W_ADDR-1:0] w_wb_addr [N_WB];
    logic [W_TAG-1:0]  w_wb_tag  [N_WB];
    logic [W_OPR-1:0]  w_wb_data [N_WB];
    logic [N_WB-1:0]   w_acc;
    logic [N_WB-1:0]   w_win;
    logic [N_REG-1:0]  w_we;
    logic [W_OPR-1:0]  w_wd [N_REG];
    logic [W_ADDR-1:0] w_rd_addr [N_RD];

    // Register 0 (when hardwired) and addresses beyond N_REG hold no state.
    function automatic logic f_legal(input logic [W_ADDR-1:0] a);
        return (32'(a) < 32'(N_REG)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        for (int unsigned j = 0; j < N_WB; j++) begin
            w_wb_addr[j] = wb_addr_i[j*W_ADDR +: W_ADDR];
            w_wb_tag[j]  = wb_tag_i[j*W_TAG +: W_TAG];
            w_wb_data[j] = wb_data_i[j*W_OPR +: W_OPR];
        end
    end

    always_comb begin
        w_acc = '0;
        for (int unsigned j = 0; j < N_WB; j++) begin
            if (wb_valid_i[j] && !flush_i && f_legal(w_wb_addr[j])) begin
                w_acc[j] = r_busy[w_wb_addr[j]] && (r_tag[w_wb_addr[j]] == w_wb_tag[j]);
            end
        end
    end

    // Lowest-index accepted port wins an address; winners are unique per address.
    always_comb begin
        w_win = w_acc;
        for (int unsigned j = 1; j < N_WB; j++) begin
            for (int unsigned i = 0; i < j; i++) begin
                if (w_acc[i] && (w_wb_addr[i] == w_wb_addr[j])) begin
                    w_win[j] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_we = '0;
        for (int unsigned r = 0; r < N_REG; r++) begin
            w_wd[r] = '0;
        end
        for (int unsigned r = 0; r < N_REG; r++) begin
            for (int unsigned j = 0; j < N_WB; j++) begin
                if (w_win[j] && (32'(w_wb_addr[j]) == r)) begin
                    w_we[r] = 1'b1;
                    w_wd[r] = w_wb_data[j];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            w_rd_addr[k] = rd_addr_i[k*W_ADDR +: W_ADDR];
            if (f_legal(w_rd_addr[k])) begin
                rd_data_o[k*W_OPR +: W_OPR] = r_data[w_rd_addr[k]];
                rd_busy_o[k]                = r_busy[w_rd_addr[k]];
                for (int unsigned j = 0; j < N_WB; j++) begin
                    if (w_win[j] && (w_wb_addr[j] == w_rd_addr[k])) begin
                        rd_data_o[k*W_OPR +: W_OPR] = w_wb_data[j];
                        rd_busy_o[k]                = 1'b0;
                    end
                end
            end
        end
    end

    // Priority within the cycle: write-back release, then flush, then the new reservation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
            for (int unsigned r = 0; r < N_REG; r++) begin
                r_data[r] <= '0;
                r_tag[r]  <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < N_REG; r++) begin
                if (w_we[r]) begin
                    r_data[r] <= w_wd[r];
                    r_busy[r] <= 1'b0;
                end
                if (flush_i) begin
                    r_busy[r] <= 1'b0;
                end
                if (res_valid_i && f_legal(res_addr_i) && (32'(res_addr_i) == r)) begin
                    r_busy[r] <= 1'b1;
                    r_tag[r]  <= res_tag_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: the driver queues expected read results and a negedge monitor checks them.
module tb_regfile_scoreboard;

    localparam int W_OPR  = 32;
    localparam int N_REG  = 32;
    localparam int N_RD   = 2;
    localparam int N_WB   = 2;
    localparam int W_TAG  = 4;
    localparam int W_ADDR = 5;

    logic                    clk;
    logic                    rst;
    logic [N_RD*W_ADDR-1:0]  rd_addr_i;
    logic [N_RD*W_OPR-1:0]   rd_data_o;
    logic [N_RD-1:0]         rd_busy_o;
    logic                    res_valid_i;
    logic [W_ADDR-1:0]       res_addr_i;
    logic [W_TAG-1:0]        res_tag_i;
    logic [N_WB-1:0]         wb_valid_i;
    logic [N_WB*W_ADDR-1:0]  wb_addr_i;
    logic [N_WB*W_TAG-1:0]   wb_tag_i;
    logic [N_WB*W_OPR-1:0]   wb_data_i;
    logic                    flush_i;

    regfile_scoreboard #(
        .W_OPR(W_OPR), .N_REG(N_REG), .N_RD(N_RD), .N_WB(N_WB), .W_TAG(W_TAG), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
        .res_valid_i(res_valid_i), .res_addr_i(res_addr_i), .res_tag_i(res_tag_i),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_tag_i(wb_tag_i),
        .wb_data_i(wb_data_i), .flush_i(flush_i)
    );

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    logic chk_en;
    int   cmp_cnt;
    int   fail_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (sb_q.size() == 0) begin
                cmp_cnt++;
                fail_cnt++;
                $display("FAIL sb_empty: got read with no expectation, want queued entry");
            end else begin
                m_e = sb_q.pop_front();
                cmp({m_e.name, ".p0.data"}, rd_data_o[31:0], m_e.d0);
                cmp({m_e.name, ".p0.busy"}, {31'b0, rd_busy_o[0]}, {31'b0, m_e.b0});
                cmp({m_e.name, ".p1.data"}, rd_data_o[63:32], m_e.d1);
                cmp({m_e.name, ".p1.busy"}, {31'b0, rd_busy_o[1]}, {31'b0, m_e.b1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        res_valid_i = 1'b0;
        wb_valid_i  = '0;
        flush_i     = 1'b0;
        chk_en      = 1'b0;
    endtask

    task automatic rsv(input int a, input int t);
        res_valid_i = 1'b1;
        res_addr_i  = W_ADDR'(a);
        res_tag_i   = W_TAG'(t);
    endtask

    task automatic wb(input int p, input int a, input int t, input logic [31:0] d);
        wb_valid_i[p]                = 1'b1;
        wb_addr_i[p*W_ADDR +: W_ADDR] = W_ADDR'(a);
        wb_tag_i[p*W_TAG +: W_TAG]    = W_TAG'(t);
        wb_data_i[p*W_OPR +: W_OPR]   = d;
    endtask

    task automatic expect_rd(input string n, input int a0, input logic [31:0] d0, input logic b0,
                             input int a1, input logic [31:0] d1, input logic b1);
        exp_t e;
        rd_addr_i = {W_ADDR'(a1), W_ADDR'(a0)};
        e.name = n; e.d0 = d0; e.b0 = b0; e.d1 = d1; e.b1 = b1;
        sb_q.push_back(e);
        chk_en = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cmp_cnt = 0; fail_cnt = 0; chk_en = 1'b0;
        rst = 1'b0; res_valid_i = 1'b0; res_addr_i = '0; res_tag_i = '0;
        wb_valid_i = '0; wb_addr_i = '0; wb_tag_i = '0; wb_data_i = '0;
        flush_i = 1'b0; rd_addr_i = '0;
        repeat (2) begin tick(); rst = 1'b0; end
        tick();

        for (int r = 0; r < N_REG; r += 2) begin
            expect_rd("reset", r, 0, 0, r + 1, 0, 0);
            tick();
        end

        // reserve / write-back / bypass
        rsv(5, 3); expect_rd("rsv_same_cycle", 5, 0, 0, 5, 0, 0); tick();
        expect_rd("rsv_busy", 5, 0, 1, 0, 0, 0); tick();
        wb(0, 5, 3, 32'hDEADBEEF);
        expect_rd("wb_bypass", 5, 32'hDEADBEEF, 0, 5, 32'hDEADBEEF, 0); tick();
        expect_rd("wb_cell", 5, 32'hDEADBEEF, 0, 7, 0, 0); tick();

        // WAW
        rsv(7, 1); tick();
        rsv(7, 2); tick();
        wb(0, 7, 1, 32'h11); expect_rd("waw_stale", 7, 0, 1, 5, 32'hDEADBEEF, 0); tick();
        expect_rd("waw_stale_after", 7, 0, 1, 7, 0, 1); tick();
        wb(1, 7, 2, 32'h22); expect_rd("waw_bypass", 7, 32'h22, 0, 7, 32'h22, 0); tick();
        expect_rd("waw_cell", 7, 32'h22, 0, 0, 0, 0); tick();

        // simultaneous ports and reserve+write-back
        rsv(9, 4); tick();
        wb(0, 9, 4, 32'hA); wb(1, 9, 4, 32'hB);
        expect_rd("dual_wb_bypass", 9, 32'hA, 0, 9, 32'hA, 0); tick();
        expect_rd("dual_wb_cell", 9, 32'hA, 0, 9, 32'hA, 0); tick();
        rsv(9, 5); tick();
        rsv(9, 6); wb(1, 9, 5, 32'hC);
        expect_rd("rsv_wb_bypass", 9, 32'hC, 0, 9, 32'hC, 0); tick();
        expect_rd("rsv_wb_cell", 9, 32'hC, 1, 9, 32'hC, 1); tick();
        wb(0, 9, 5, 32'hD); expect_rd("old_tag_drop", 9, 32'hC, 1, 9, 32'hC, 1); tick();
        wb(0, 9, 6, 32'hE); expect_rd("new_tag_bypass", 9, 32'hE, 0, 9, 32'hE, 0); tick();
        expect_rd("new_tag_cell", 9, 32'hE, 0, 9, 32'hE, 0); tick();

        // flush
        rsv(1, 1); tick();
        rsv(2, 2); tick();
        rsv(3, 3); expect_rd("pre_flush", 1, 0, 1, 2, 0, 1); tick();
        flush_i = 1'b1; rsv(4, 7); wb(0, 1, 1, 32'h55);
        expect_rd("flush_cycle", 1, 0, 1, 4, 0, 0); tick();
        expect_rd("post_flush_a", 1, 0, 0, 4, 0, 1); tick();
        expect_rd("post_flush_b", 2, 0, 0, 3, 0, 0); tick();

        // register 0
        rsv(0, 1); expect_rd("r0_rsv", 0, 0, 0, 0, 0, 0); tick();
        wb(0, 0, 1, 32'h99); expect_rd("r0_wb", 0, 0, 0, 0, 0, 0); tick();
        expect_rd("r0_after", 0, 0, 0, 4, 0, 1); tick();

        // reset mid-operation
        rsv(6, 2); tick();
        expect_rd("r6_busy", 6, 0, 1, 5, 32'hDEADBEEF, 0); tick();
        rst = 1'b0; wb(0, 6, 2, 32'h77); tick();
        expect_rd("mid_reset_a", 6, 0, 0, 5, 0, 0); tick();
        expect_rd("mid_reset_b", 9, 0, 0, 4, 0, 0); tick();
        tick();

        cmp_cnt++;
        if (sb_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port register file with a per-register write-reserve scoreboard, used between decode/issue and the write-back stage. It holds N_REG operands of W_OPR bits. Issue marks destination registers as reserved with an instruction tag. Write-back ports deliver results that update data and release the reservation only when the tag matches the newest reservation. It adds multiple read ports, same-cycle write-back bypass and a global flush for mispredict recovery.

## Interface
- W_OPR, 32, operand width in bits
- N_REG, 32, number of registers; W_ADDR = clog2(N_REG)
- N_RD, 2, number of read ports
- N_WB, 2, number of write-back ports
- W_TAG, 4, reservation tag width
- ZERO_REG, 1, when 1: register 0 reads 0 and is never reserved or written
- clk  in  1  clock, all state updates on its rising edge
- rst  in  1  reset, synchronous, active-low; applied on a rising clk edge while low
- rd_addr_i  in  N_RD*W_ADDR  read addresses; port k occupies bits [k*W_ADDR +: W_ADDR]
- rd_data_o  out  N_RD*W_OPR  read data, combinational
- rd_busy_o  out  N_RD  1 = the read register is reserved and its data is not yet valid
- res_valid_i  in  1  reserve request
- res_addr_i  in  W_ADDR  register to reserve
- res_tag_i  in  W_TAG  tag of the reserving instruction
- wb_valid_i  in  N_WB  per-port write-back strobe
- wb_addr_i  in  N_WB*W_ADDR  write-back addresses
- wb_tag_i  in  N_WB*W_TAG  write-back tags
- wb_data_i  in  N_WB*W_OPR  write-back data
- flush_i  in  1  clears all reservations

## Operation
- State per register: data[W_OPR], busy, tag[W_TAG].
- **Reset** (rst=0 at the edge): all data, busy and tag bits go to 0. This overrides every other input. After reset, rd_data_o=0 and rd_busy_o=0 on all ports.
- **Write-back acceptance.** Port j is accepted when all of these hold:
  - wb_valid_i[j]=1
  - busy[a]=1 and tag[a]=wb_tag_i[j], where a = wb_addr_i[j]
  - flush_i=0
  - a is not 0 when ZERO_REG=1
- **Rejected write-backs** are dropped silently: no data write and no busy change. This covers stale results.
- **Multiple accepted ports on one address** in the same cycle: the lowest-index port wins. The other ports are dropped.
- **Accepted write-back effect:** data[a] <= wb_data_i[j]; busy[a] <= 0.
- **Reservation.** When res_valid_i=1 and the address is legal (not register 0 when ZERO_REG=1): busy[r] <= 1 and tag[r] <= res_tag_i. Reserving an already-busy register overwrites its tag (WAW): only the newest writer can release it.
- **Reservation and accepted write-back on the same register, same cycle:** the data write happens and busy stays 1 with the new tag.
- **Flush** (flush_i=1): every busy bit goes to 0. All write-backs in that cycle are ignored. A reservation in the same cycle is still applied, after the flush.
- **Read port k, address a:**
  - If an accepted write-back targets a this cycle: rd_data = winning wb_data and rd_busy = 0 (bypass).
  - Otherwise: rd_data = data[a] and rd_busy = busy[a].
  - Reservations and flush in the same cycle are not visible to reads.
  - Register 0 with ZERO_REG=1: rd_data = 0, rd_busy = 0.
- **Out-of-range addresses** (a ≥ N_REG, when N_REG is not a power of 2): reads return 0 and not-busy; reservations and writes are ignored.

## Timing
- Reads are combinational from state and the current-cycle write-back inputs; there is no registered read latency.
- A reservation is visible on rd_busy_o one cycle after its edge.
- A write-back is visible on the read ports in the same cycle via bypass, and from the cell from the next cycle.
- A flush takes effect at the next edge; busy reads as 0 from the following cycle.
- There are no handshakes. Every input is sampled on every edge. There is no back-pressure: the issue logic guarantees at most one reservation per cycle.

## Test plan
- Reset, then read all registers -> rd_data=0 and rd_busy=0 on every port.
- Reserve r5 with tag 3; next cycle write back r5 with tag 3 and data 0xDEADBEEF; read r5 that cycle and the next -> busy=1 after the reserve, then data 0xDEADBEEF and busy=0 in the write-back cycle (bypass) and after it.
- WAW:
  - Reserve r7 with tag 1, then reserve r7 with tag 2.
  - Write back tag 1 with 0x11 -> dropped; data unchanged, busy=1.
  - Write back tag 2 with 0x22 -> data 0x22, busy=0.
- Simultaneous events:
  - Ports 0 and 1 both write back r9 with matching tag 4 (0xA, 0xB) -> data 0xA.
  - Same cycle: reserve r9 with tag 6 plus a matching write-back -> data written, busy stays 1 with tag 6.
- Flush:
  - Reserve r1, r2 and r3; assert flush together with a reserve of r4 and a matching write-back to r1.
  - Required: r1–r3 not busy and r1 data unchanged; r4 busy.
- Register 0 and reset mid-operation:
  - Reserve and write r0 -> r0 reads 0, not busy.
  - Assert rst while r6 is busy together with a matching write-back -> after the edge, r6 data=0 and busy=0.
